// File: rtl/pc_nb.sv
// Hack CPU program counter: load/increment/stall control, sticky jump-to-self
// halt detector, increment-wrap pulse and saturating accepted-cycle counter.
module pc_nb #(
   parameter int D = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [D-1:0]  i_in,
   input  logic          i_load,
   input  logic          i_inc,
   input  logic          i_stall,
   output logic [D-1:0]  o_out,
   output logic          o_halt,
   output logic          o_wrap,
   output logic [31:0]   o_cycles
);

   logic [D-1:0] pc_q, pc_d;
   logic         pc_en_s;
   logic         halt_q, halt_d;
   logic         wrap_q, wrap_d;
   logic [31:0]  cycles_q, cycles_d;

   // Next-state selection in priority order: stall, halted, load, increment, idle
   always_comb begin
      pc_d     = pc_q;
      pc_en_s  = 1'b0;
      halt_d   = halt_q;
      wrap_d   = 1'b0;
      cycles_d = cycles_q;
      if (i_stall) begin
         pc_en_s = 1'b0;
      end else if (halt_q) begin
         pc_en_s = 1'b0;
      end else begin
         if (cycles_q == 32'hFFFF_FFFF) begin
            cycles_d = cycles_q;
         end else begin
            cycles_d = cycles_q + 32'd1;
         end
         if (i_load) begin
            pc_d    = i_in;
            pc_en_s = 1'b1;
            // Hack end-of-program idiom: unconditional jump to the current address
            if (i_in == pc_q) begin
               halt_d = 1'b1;
            end else begin
               halt_d = halt_q;
            end
         end else if (i_inc) begin
            pc_d    = pc_q + D'(1);
            pc_en_s = 1'b1;
            if (pc_q == {D{1'b1}}) begin
               wrap_d = 1'b1;
            end else begin
               wrap_d = 1'b0;
            end
         end else begin
            pc_en_s = 1'b0;
         end
      end
   end

   // State registers; the PC register is clock-enabled
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q     <= {D{1'b0}};
         halt_q   <= 1'b0;
         wrap_q   <= 1'b0;
         cycles_q <= 32'd0;
      end else begin
         if (pc_en_s) begin
            pc_q <= pc_d;
         end
         halt_q   <= halt_d;
         wrap_q   <= wrap_d;
         cycles_q <= cycles_d;
      end
   end

   assign o_out    = pc_q;
   assign o_halt   = halt_q;
   assign o_wrap   = wrap_q;
   assign o_cycles = cycles_q;

endmodule

// File: doc/pc_nb.md
# pc_nb

Program counter for the Hack CPU datapath. It sits directly upstream of the instruction ROM and drives its address; its next-address input comes from the A register through the jump logic. It is a parameterised-width register with reset, load and increment control. It also has a stall override, a sticky halt detector for the Hack end-of-program idiom (an unconditional jump to self), an increment-wrap flag and a saturating executed-cycle counter.

## Interface
- D, default 16, width of the address held and output.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- i_in  input  D  jump target, taken when i_load is accepted.
- i_load  input  1  load request (jump taken).
- i_inc  input  1  increment request (normal sequential fetch).
- i_stall  input  1  freeze all state this cycle.
- o_out  output  D  current program counter; ROM address.
- o_halt  output  1  sticky: a jump-to-self has been executed.
- o_wrap  output  1  one-cycle pulse: the last increment wrapped all-ones to zero.
- o_cycles  output  32  count of accepted (non-stalled, non-halted) cycles, saturating.

## Operation
- Single clock, synchronous active-high reset, all outputs registered. No combinational path from inputs to outputs.
- Per-edge priority, highest first:
  1. rst_i: o_out=0, o_halt=0, o_wrap=0, o_cycles=0.
  2. i_stall: every register holds, including o_cycles and o_halt. o_wrap drops to 0.
  3. o_halt==1: o_out holds. i_load and i_inc are ignored. o_cycles holds. o_wrap=0.
  4. i_load: o_out<=i_in. If i_in==o_out, then o_halt<=1.
  5. i_inc: o_out<=o_out+1, modulo 2^D. If o_out was all-ones, o_wrap<=1.
  6. Otherwise: o_out holds.
- i_load has priority over i_inc when both are asserted. A simultaneous load of the current address still sets halt.
- o_wrap is 1 only in the cycle after a wrapping increment; otherwise it is 0.
- o_cycles increments on every edge that reaches priority 4, 5 or 6, so idle hold cycles count. It saturates at 32'hFFFF_FFFF and never wraps.
- Once set, o_halt clears only through rst_i. i_stall does not clear it.
- Implementation is a D-bit register plus next-state mux, an equality comparator, a halt flop, a wrap flop and a 32-bit counter. The PC register must be clock-enabled: it loads only when priority 1, 4 or 5 applies.

## Timing
- Latency is one cycle from request to o_out. ROM data for the new address is valid in the cycle after o_out changes (the ROM is external and synchronous).
- Reset value of every output is 0. Applying rst_i for one edge is sufficient.
- Reset mid-stall or mid-halt: rst_i wins, and all state clears at that edge.
- Stall release: operation resumes on the first edge with i_stall=0, with no lost or duplicated increment.
- Halt detection compares i_in against the registered o_out of the same cycle. o_halt rises on the same edge at which the load is taken.
- Boundary conditions:
  - Incrementing at all-ones wraps o_out to 0 and pulses o_wrap.
  - A load of all-ones followed by an increment also wraps.
  - o_cycles holds at saturation.

## Test plan
- Reset then sequential fetch: rst_i for 1 edge, then i_inc=1 for 5 edges -> o_out steps 0,1,2,3,4,5. o_cycles=5, o_halt=0, o_wrap=0 throughout.
- Load priority: o_out=3, i_load=1, i_inc=1, i_in=16'h0100 -> o_out=16'h0100 next edge, with no increment applied. Then i_inc -> 16'h0101.
- Halt: o_out=16'h0010, i_load=1, i_in=16'h0010 -> o_halt=1 on that edge. Then i_load with i_in=16'h0020, plus i_inc, for 4 edges -> o_out stays 16'h0010 and o_cycles frozen. Then rst_i -> all outputs 0.
- Wrap: load 16'hFFFF, then i_inc -> o_out=16'h0000 and o_wrap=1 for exactly one cycle. The next i_inc gives o_out=1 and o_wrap=0.
- Stall: o_out=7, i_stall=1 with i_inc=1 for 3 edges -> o_out=7 and o_cycles unchanged. Release the stall -> o_out=8 after one edge. i_stall together with a self-load -> o_halt stays 0.
- Saturation (bench forces o_cycles to 32'hFFFF_FFFE): 3 accepted edges -> o_cycles=32'hFFFF_FFFF and holds there.
